// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP control sequencer: opcodes, control-word bit
// positions, the per-T-state control words and the one-hot ring encoding.
package sap_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CW_CP  = 11;
    localparam int CW_EP  = 10;
    localparam int CW_NLM = 9;
    localparam int CW_NCE = 8;
    localparam int CW_NLI = 7;
    localparam int CW_NEI = 6;
    localparam int CW_NLA = 5;
    localparam int CW_EA  = 4;
    localparam int CW_SU  = 3;
    localparam int CW_EU  = 2;
    localparam int CW_NLB = 1;
    localparam int CW_NLO = 0;

    localparam logic [11:0] CW_IDLE    = 12'h3E3;
    localparam logic [11:0] CW_FETCH_1 = 12'h5E3;
    localparam logic [11:0] CW_FETCH_2 = 12'hBE3;
    localparam logic [11:0] CW_FETCH_3 = 12'h263;
    // T4 for LDA/ADD/SUB: IR operand field drives the bus into the MAR.
    localparam logic [11:0] CW_ADDR_T4 = 12'h1A3;
    localparam logic [11:0] CW_LDA_T5  = 12'h2C3;
    localparam logic [11:0] CW_ALU_T5  = 12'h2E1;
    localparam logic [11:0] CW_ADD_T6  = 12'h3C7;
    localparam logic [11:0] CW_SUB_T6  = 12'h3CF;
    localparam logic [11:0] CW_OUT_T4  = 12'h3F2;

    typedef enum logic [5:0] {
        ST_T1 = 6'b000001,
        ST_T2 = 6'b000010,
        ST_T3 = 6'b000100,
        ST_T4 = 6'b001000,
        ST_T5 = 6'b010000,
        ST_T6 = 6'b100000
    } t_state_e;

    function automatic logic is_one_hot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

endpackage

// File: rtl/sap_control_sequencer_t_ring_counter.sv
// Six-position one-hot T-state ring, stepped on the falling clock edge so the
// decoded control word is settled at the rising edge the datapath uses.
module t_ring_counter
    import sap_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       advance,
    output logic [5:0] ring
);

    logic [5:0] ring_r;
    logic [5:0] ring_next_s;

    // Next ring value: any non-one-hot value is forced back to T1.
    always_comb begin
        ring_next_s = ring_r;
        if (!is_one_hot6(ring_r)) begin
            ring_next_s = ST_T1;
        end else if (advance) begin
            ring_next_s = {ring_r[4:0], ring_r[5]};
        end else begin
            ring_next_s = ring_r;
        end
    end

    // Ring register with asynchronous clear.
    always_ff @(negedge clk or posedge clear) begin
        if (clear) begin
            ring_r <= ST_T1;
        end else begin
            ring_r <= ring_next_s;
        end
    end

    assign ring = ring_r;

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control unit: T-state ring, sticky halt flag, and the Moore decode of
// ring position and opcode into the bus control word.
module sap_control_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int CW_W     = 12
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [CW_W-1:0]     control_word,
    output logic [5:0]          t_state,
    output logic                halted
);

    logic [5:0]      ring_s;
    logic            halted_r;
    logic            halt_set_s;
    logic            advance_s;
    logic [CW_W-1:0] cw_s;

    // HLT stops the ring at T4 on the edge that would otherwise leave it.
    assign halt_set_s = run & ~halted_r & (ring_s == ST_T4) & (opcode == OP_HLT);
    assign advance_s  = run & ~halted_r & ~halt_set_s;

    t_ring_counter u_ring (
        .clk     (clk),
        .clear   (clear),
        .advance (advance_s),
        .ring    (ring_s)
    );

    // Sticky halt flag, cleared only by clear.
    always_ff @(negedge clk or posedge clear) begin
        if (clear) begin
            halted_r <= 1'b0;
        end else if (halt_set_s) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    // Control-word decode; idle whenever the sequencer is not actively stepping.
    always_comb begin
        cw_s = CW_IDLE;
        if (clear || !run || halted_r) begin
            cw_s = CW_IDLE;
        end else begin
            case (ring_s)
                ST_T1:   cw_s = CW_FETCH_1;
                ST_T2:   cw_s = CW_FETCH_2;
                ST_T3:   cw_s = CW_FETCH_3;
                ST_T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: cw_s = CW_ADDR_T4;
                        OP_OUT:                 cw_s = CW_OUT_T4;
                        default:                cw_s = CW_IDLE;
                    endcase
                end
                ST_T5: begin
                    case (opcode)
                        OP_LDA:         cw_s = CW_LDA_T5;
                        OP_ADD, OP_SUB: cw_s = CW_ALU_T5;
                        default:        cw_s = CW_IDLE;
                    endcase
                end
                ST_T6: begin
                    case (opcode)
                        OP_ADD:  cw_s = CW_ADD_T6;
                        OP_SUB:  cw_s = CW_SUB_T6;
                        default: cw_s = CW_IDLE;
                    endcase
                end
                default: cw_s = CW_IDLE;
            endcase
        end
    end

    assign control_word = cw_s;
    assign t_state      = ring_s;
    assign halted       = halted_r;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed scoreboard bench for sap_control_sequencer: expected words are
// queued as each step is driven and compared at the following rising edge.
module tb_sap_control_sequencer;

    logic        clk;
    logic        clear;
    logic        run;
    logic [3:0]  opcode;
    logic [11:0] control_word;
    logic [5:0]  t_state;
    logic        halted;

    int checks = 0;
    int errors = 0;
    int cp_seen = 0;
    logic [18:0] exp_q[$];

    sap_control_sequencer #(.OPCODE_W(4), .CW_W(12)) dut (
        .clk          (clk),
        .clear        (clear),
        .run          (run),
        .opcode       (opcode),
        .control_word (control_word),
        .t_state      (t_state),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [11:0] cw, input logic [5:0] ts, input logic h);
        exp_q.push_back({h, ts, cw});
    endtask

    task automatic check_now(input string tag);
        logic [18:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            if (control_word[11]) cp_seen++;
            assert ({halted, t_state, control_word} === e) else begin
                errors++;
                $error("FAIL %s: cw got %h exp %h, t_state got %b exp %b, halted got %b exp %b",
                       tag, control_word, e[11:0], t_state, e[17:12], halted, e[18]);
            end
        end
    endtask

    task automatic cyc(input logic [11:0] cw, input logic [5:0] ts, input logic h, input string tag);
        push_exp(cw, ts, h);
        @(posedge clk);
        check_now(tag);
    endtask

    task automatic fetch(input string tag);
        cyc(12'h5E3, 6'b000001, 1'b0, {tag, "_t1"});
        cyc(12'hBE3, 6'b000010, 1'b0, {tag, "_t2"});
        cyc(12'h263, 6'b000100, 1'b0, {tag, "_t3"});
    endtask

    initial begin
        clear = 1'b1; run = 1'b0; opcode = 4'h0;
        #1;
        push_exp(12'h3E3, 6'b000001, 1'b0);
        check_now("reset");
        #1;
        clear = 1'b0; run = 1'b1;

        // LDA full instruction, cp must be high at exactly one rising edge
        cp_seen = 0;
        fetch("lda");
        cyc(12'h1A3, 6'b001000, 1'b0, "lda_t4");
        cyc(12'h2C3, 6'b010000, 1'b0, "lda_t5");
        cyc(12'h3E3, 6'b100000, 1'b0, "lda_t6");
        checks++;
        assert (cp_seen === 1) else begin
            errors++;
            $error("FAIL lda_cp_count: got %0d exp 1", cp_seen);
        end

        // ADD
        cyc(12'h5E3, 6'b000001, 1'b0, "add_t1");
        opcode = 4'h1;
        cyc(12'hBE3, 6'b000010, 1'b0, "add_t2");
        cyc(12'h263, 6'b000100, 1'b0, "add_t3");
        cyc(12'h1A3, 6'b001000, 1'b0, "add_t4");
        cyc(12'h2E1, 6'b010000, 1'b0, "add_t5");
        cyc(12'h3C7, 6'b100000, 1'b0, "add_t6");

        // SUB, with an opcode glitch during fetch that must not matter
        cyc(12'h5E3, 6'b000001, 1'b0, "sub_t1");
        opcode = 4'hF;
        cyc(12'hBE3, 6'b000010, 1'b0, "sub_opglitch_t2");
        opcode = 4'h2;
        cyc(12'h263, 6'b000100, 1'b0, "sub_t3");
        cyc(12'h1A3, 6'b001000, 1'b0, "sub_t4");
        cyc(12'h2E1, 6'b010000, 1'b0, "sub_t5");
        cyc(12'h3CF, 6'b100000, 1'b0, "sub_t6");

        // OUT
        cyc(12'h5E3, 6'b000001, 1'b0, "out_t1");
        opcode = 4'hE;
        cyc(12'hBE3, 6'b000010, 1'b0, "out_t2");
        cyc(12'h263, 6'b000100, 1'b0, "out_t3");
        cyc(12'h3F2, 6'b001000, 1'b0, "out_t4");
        cyc(12'h3E3, 6'b010000, 1'b0, "out_t5");
        cyc(12'h3E3, 6'b100000, 1'b0, "out_t6");

        // Undefined opcode behaves as NOP and the ring wraps
        cyc(12'h5E3, 6'b000001, 1'b0, "nop_t1");
        opcode = 4'h7;
        cyc(12'hBE3, 6'b000010, 1'b0, "nop_t2");
        cyc(12'h263, 6'b000100, 1'b0, "nop_t3");
        cyc(12'h3E3, 6'b001000, 1'b0, "nop_t4");
        cyc(12'h3E3, 6'b010000, 1'b0, "nop_t5");
        cyc(12'h3E3, 6'b100000, 1'b0, "nop_t6");
        cyc(12'h5E3, 6'b000001, 1'b0, "nop_wrap_t1");

        // Illegal ring value recovers to T1 on the next falling edge
        force dut.u_ring.ring_r = 6'b000011;
        #1;
        release dut.u_ring.ring_r;
        cyc(12'h5E3, 6'b000001, 1'b0, "seu_recover");

        // Pause in T2
        @(negedge clk);
        #1 run = 1'b0;
        for (int i = 0; i < 5; i++) cyc(12'h3E3, 6'b000010, 1'b0, "pause_t2");
        @(negedge clk);
        #1 run = 1'b1;
        cp_seen = 0;
        cyc(12'hBE3, 6'b000010, 1'b0, "resume_t2");
        cyc(12'h263, 6'b000100, 1'b0, "resume_t3");
        checks++;
        assert (cp_seen === 1) else begin
            errors++;
            $error("FAIL resume_cp_count: got %0d exp 1", cp_seen);
        end
        cyc(12'h3E3, 6'b001000, 1'b0, "resume_t4");
        cyc(12'h3E3, 6'b010000, 1'b0, "resume_t5");
        cyc(12'h3E3, 6'b100000, 1'b0, "resume_t6");

        // Clear asserted mid-T5 takes effect immediately
        cyc(12'h5E3, 6'b000001, 1'b0, "clr_t1");
        opcode = 4'h0;
        cyc(12'hBE3, 6'b000010, 1'b0, "clr_t2");
        cyc(12'h263, 6'b000100, 1'b0, "clr_t3");
        cyc(12'h1A3, 6'b001000, 1'b0, "clr_t4");
        cyc(12'h2C3, 6'b010000, 1'b0, "clr_t5");
        #1 clear = 1'b1;
        #1;
        push_exp(12'h3E3, 6'b000001, 1'b0);
        check_now("clear_mid_t5");
        @(negedge clk);
        #1 clear = 1'b0;
        cyc(12'h5E3, 6'b000001, 1'b0, "post_clear_t1");
        cyc(12'hBE3, 6'b000010, 1'b0, "post_clear_t2");
        opcode = 4'hF;

        // HLT: stop at T4 and stay there
        cyc(12'h263, 6'b000100, 1'b0, "hlt_t3");
        cyc(12'h3E3, 6'b001000, 1'b0, "hlt_t4");
        for (int i = 0; i < 20; i++) cyc(12'h3E3, 6'b001000, 1'b1, "halted_hold");
        #1 clear = 1'b1;
        #1;
        push_exp(12'h3E3, 6'b000001, 1'b0);
        check_now("halt_clear");
        @(negedge clk);
        #1 begin clear = 1'b0; opcode = 4'h0; end
        cyc(12'h5E3, 6'b000001, 1'b0, "after_halt_t1");
        cyc(12'hBE3, 6'b000010, 1'b0, "after_halt_t2");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
